// File: rtl/spi_out.sv
// Multi-lane SPI master transmitter: takes a parallel word via valid/ready and shifts it out MSB first
// on DATA_QUANTITY lanes with a framing enable, data changing on spi_clock falling edges.
module spi_out #(
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_QUANTITY = 2,
    parameter int CLK_DIV       = 4,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH*DATA_QUANTITY-1:0] data_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    output logic                                spi_clock,
    output logic                                en,
    output logic [DATA_QUANTITY-1:0]            data_out,
    output logic                                busy,
    output logic                                done_signal
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [DATA_QUANTITY-1:0][DATA_WIDTH-1:0] data_lanes;
    // The MSB of each lane goes straight to data_out on load, so only the remaining bits are kept here.
    logic [DATA_QUANTITY-1:0][DATA_WIDTH-2:0] shreg;

    logic                     handshake;
    logic                     div_end;
    logic                     gap_end;
    logic                     en_d;
    logic                     spi_clock_d;
    logic                     ready_d;
    logic                     busy_d;
    logic                     done_d;
    logic [DATA_QUANTITY-1:0] data_d;

    assign data_lanes = data_in;
    assign handshake  = valid_in && ready_out;
    assign div_end    = (div_cnt == DIV_LAST);
    assign gap_end    = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = SETUP;
            SETUP:   if (div_end) state_next = HIGH;
            HIGH:    if (div_end) state_next = (bit_cnt == BIT_LAST) ? HOLD : LOW;
            LOW:     if (div_end) state_next = HIGH;
            HOLD:    if (div_end) state_next = GAP;
            GAP:     if (gap_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they change with the state.
    always_comb begin
        en_d        = (state_next inside {SETUP, HIGH, LOW, HOLD});
        spi_clock_d = (state_next == HIGH);
        ready_d     = (state_next == IDLE);
        busy_d      = (state_next != IDLE);
        done_d      = (state_next == GAP) && (state != GAP);
        data_d      = data_out;
        if (state == IDLE && state_next == SETUP) begin
            for (int unsigned i = 0; i < DATA_QUANTITY; i++) begin
                data_d[i] = data_lanes[i][DATA_WIDTH-1];
            end
        end else if (state == HIGH && state_next == LOW) begin
            for (int unsigned i = 0; i < DATA_QUANTITY; i++) begin
                data_d[i] = shreg[i][DATA_WIDTH-2];
            end
        end else if (!en_d) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state_next != state) begin
                div_cnt <= '0;
            end else if (state inside {SETUP, HIGH, LOW, HOLD}) begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state_next != state) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (state == IDLE && state_next == SETUP) begin
                bit_cnt <= '0;
            end else if (state == HIGH && state_next == LOW) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == IDLE && state_next == SETUP) begin
                for (int unsigned i = 0; i < DATA_QUANTITY; i++) begin
                    shreg[i] <= data_lanes[i][DATA_WIDTH-2:0];
                end
            end else if (state == HIGH && state_next == LOW) begin
                for (int unsigned i = 0; i < DATA_QUANTITY; i++) begin
                    shreg[i] <= shreg[i] << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_clock   <= 1'b0;
            en          <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            done_signal <= 1'b0;
            ready_out   <= 1'b1;
        end else begin
            spi_clock   <= spi_clock_d;
            en          <= en_d;
            data_out    <= data_d;
            busy        <= busy_d;
            done_signal <= done_d;
            ready_out   <= ready_d;
        end
    end

endmodule
